fi_fo: RTL and testbench
========================

// Module: fi_fo
// PURPOSE
//   Synchronous single-clock 32-bit FIFO that buffers ARINC-429 words between
//   the receiver/transmitter datapath and the host-side logic.
//   - Standard (non-FWFT) read: data appears on dout one clock after an accepted read.
//   - Provides full, almost_full, empty and almost_empty status flags.
// PARAMETERS
//   WIDTH       32   data word width in bits
//   DEPTH       16   number of storage entries (power of two, >= 4)
//   ADDR_W      4    log2(DEPTH), pointer width
// PORTS
//   clk           in   1      system clock; all state changes on the rising edge
//   rst           in   1      asynchronous reset, active-low (0 = reset)
//   din           in   32     write data
//   wr_en         in   1      write request
//   rd_en         in   1      read request
//   dout          out  32     read data, registered
//   full          out  1      count == DEPTH
//   almost_full   out  1      count >= DEPTH-1
//   empty         out  1      count == 0
//   almost_empty  out  1      count <= 1
// BEHAVIOUR
//   - Reset (rst=0, asynchronous assert, synchronous release):
//     - Pointers and count cleared; dout=0.
//     - empty=1, almost_empty=1, full=0, almost_full=0.
//     - Memory contents are not cleared.
//     - Mid-operation reset discards all stored words immediately.
//   - Write is accepted on a rising edge when wr_en=1 and full=0:
//     - mem[wr_ptr] <= din; wr_ptr increments.
//     - wr_en while full is ignored; no overwrite and no state change.
//   - Read is accepted on a rising edge when rd_en=1 and empty=0:
//     - dout <= mem[rd_ptr]; rd_ptr increments. Latency is 1 clock.
//     - rd_en while empty is ignored; dout holds its last value.
//   - Acceptance is decided from the flag state before the edge.
//     - Both requests while empty: only the write occurs (count 0->1).
//     - Both requests while full: only the read occurs (count DEPTH->DEPTH-1).
//     - Both requests otherwise: both occur and count is unchanged.
//   - Pointers wrap modulo DEPTH; count is ADDR_W+1 bits wide, range 0..DEPTH.
//   - All four flags are registered and derived from the next count value, so they
//     are valid in the same cycle the count changes.
//   - Ordering is strict FIFO; no data loss across pointer wrap-around.
//   - dout is unaffected by writes.
// TESTING
//   - Reset: hold rst=0, toggle clk
//     -> empty=1, almost_empty=1, full=0, almost_full=0, dout=0.
//   - Write then read:
//     - Write 32'hABFFDECC, then 32'hABFFAACF.
//     - Then assert rd_en continuously while wr_en stays 1 (new data each cycle).
//     - Required: dout=ABFFDECC one clock after the first read edge, then ABFFAACF
//       on the following edge.
//   - Fill: 16 writes with no reads
//     -> almost_full=1 after 15 writes, full=1 after 16.
//     - A 17th write (32'hDEADBEEF) is ignored; the read-back sequence is unchanged.
//   - Drain: read 16 words from full
//     -> almost_empty=1 at count 1, empty=1 at count 0.
//     - An extra rd_en keeps dout at the last word.
//   - Simultaneous requests:
//     - wr_en=rd_en=1 while empty -> count becomes 1, dout unchanged.
//     - At count 8 -> count stays 8 across 20 cycles, data order is preserved.
//   - Wrap and reset:
//     - Run 40 interleaved writes and reads, then pull rst low mid-stream.
//     - Required: flags return to reset values immediately, without waiting for a
//       clock edge.

Source files
------------

// File: rtl/fi_fo.sv
// Purpose : single-clock 32-bit FIFO buffering ARINC-429 words between the datapath and host logic.
// Latency : standard (non-FWFT) read; dout updates one clock after an accepted read.
// Backpress: writes are dropped while full and reads are ignored while empty; the status flags are the flow control.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   din          write data
//   wr_en        write request, accepted when not full
//   rd_en        read request, accepted when not empty
//   dout         registered read data, holds its value when no read is accepted
//   full         count == DEPTH
//   almost_full  count >= DEPTH-1
//   empty        count == 0
//   almost_empty count <= 1
module fi_fo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic             almost_empty
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    // This makes "both while empty" a pure write and "both while full" a pure read.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            end
            if (rd_acc) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            // Flags come from the next count so they line up with the count register.
            full         <= (count_nxt == CNT_FULL);
            almost_full  <= (count_nxt >= CNT_AF);
            empty        <= (count_nxt == '0);
            almost_empty <= (count_nxt <= CNT_ONE);
        end
    end

endmodule

// File: tb/tb_fi_fo.sv
module tb_fi_fo;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] dout;
    logic        full;
    logic        almost_full;
    logic        empty;
    logic        almost_empty;

    int          n_vec;
    int          n_err;

    // Scoreboard: words pushed on accepted writes, popped on accepted reads.
    logic [31:0] sb [$];
    int          m_cnt;
    logic [31:0] exp_dout;

    fi_fo #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " dout"},         dout,                 exp_dout);
        check({tag, " full"},         32'(full),            32'(m_cnt == 16));
        check({tag, " almost_full"},  32'(almost_full),     32'(m_cnt >= 15));
        check({tag, " empty"},        32'(empty),           32'(m_cnt == 0));
        check({tag, " almost_empty"}, 32'(almost_empty),    32'(m_cnt <= 1));
    endtask

    // One clock of stimulus; the model decides acceptance from its own pre-edge count.
    task automatic step(input logic w, input logic r, input logic [31:0] d, input string tag);
        logic wa;
        logic ra;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        wa = w && (m_cnt != 16);
        ra = r && (m_cnt != 0);
        @(posedge clk);
        #1;
        if (ra) exp_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        m_cnt = m_cnt + int'(wa) - int'(ra);
        check_state(tag);
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt    = 0;
        exp_dout = 32'h0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        din   = 32'h0;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Reset held across clock edges.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Write then read while writes continue.
        step(1'b1, 1'b0, 32'hABFFDECC, "wr0");
        step(1'b1, 1'b0, 32'hABFFAACF, "wr1");
        step(1'b1, 1'b1, 32'h11110001, "rw0");
        check("first_read", dout, 32'hABFFDECC);
        step(1'b1, 1'b1, 32'h11110002, "rw1");
        check("second_read", dout, 32'hABFFAACF);
        step(1'b1, 1'b1, 32'h11110003, "rw2");
        // Drain back to empty.
        for (int i = 0; i < 6 && m_cnt > 0; i++) step(1'b0, 1'b1, 32'h0, "drain_a");
        check("empty_after_drain_a", 32'(empty), 32'd1);

        // Fill to full, then an ignored 17th write.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 32'hC0DE0000 + 32'(i), "fill");
            if (i == 14) check("almost_full_at_15", 32'(almost_full), 32'd1);
            if (i == 14) check("not_full_at_15", 32'(full), 32'd0);
        end
        check("full_at_16", 32'(full), 32'd1);
        step(1'b1, 1'b0, 32'hDEADBEEF, "overfill");

        // Drain 16 words, then one extra read.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 32'h0, "drain");
            check("drain_order", dout, 32'hC0DE0000 + 32'(i));
            if (i == 14) check("almost_empty_at_1", 32'(almost_empty), 32'd1);
        end
        check("empty_at_0", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 32'h0, "extra_rd");
        check("extra_rd_hold", dout, 32'hC0DE000F);

        // Simultaneous requests while empty: only the write happens.
        step(1'b1, 1'b1, 32'h5A5A0001, "both_empty");
        check("both_empty_hold", dout, 32'hC0DE000F);
        check("both_empty_cnt1", 32'(almost_empty & ~empty), 32'd1);

        // Bring count to 8, then 20 cycles of simultaneous read/write.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h5A5A0002 + 32'(i), "to8");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h77770000 + 32'(i), "steady8");
        check("steady8_count", 32'(m_cnt), 32'd8);
        // Simultaneous requests while full: only the read happens.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h88880000 + 32'(i), "to16");
        step(1'b1, 1'b1, 32'h99999999, "both_full");
        check("both_full_cnt15", 32'(almost_full & ~full), 32'd1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 32'h0, "drain_b");

        // Interleaved traffic across pointer wrap, then async reset mid-stream.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 $urandom(), "wrap");
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hA5A50000 + 32'(i), "prefill");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0BADF00D, "post_rst_wr");
        step(1'b0, 1'b1, 32'h0, "post_rst_rd");
        check("post_rst_data", dout, 32'h0BADF00D);

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
